// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory side of the system.
// Holds the core count, the memory geometry, and the requester id type.
// The UART memory-communication interface is always the requester just
// after the last core.
package dmem_pkg;

  localparam int CORE_COUNT          = 4;
  localparam int REG_WIDTH           = 48;
  localparam int DATA_MEM_WIDTH      = 48;
  localparam int DATA_MEM_ADDR_WIDTH = 12;
  localparam int UART_REQ_ID         = CORE_COUNT;
  localparam int REQ_COUNT           = CORE_COUNT + 1;

  // Index of a requester on the data-memory arbiter (cores, then UART).
  typedef logic [$clog2(REQ_COUNT)-1:0] reqId_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker (purely combinational).
// It scans the request vector starting one position after the last winner
// and wraps modulo N. N does not have to be a power of two.
//   req    : request vector, one bit per requester
//   last   : index of the previous winner
//   gnt    : one-hot grant, all zero when req == 0
//   winner : index of the granted requester, 0 when req == 0
module rr_pick #(
  parameter int N     = 5,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] winner
);

  always_comb begin
    logic             found;
    int               idxI;
    logic [PTR_W-1:0] idx;
    // NOTE: every variable gets a default before the loop, so no path
    // leaves one unassigned and no latch is inferred.
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idxI   = 0;
    idx    = '0;
    for (int off = 1; off <= N; off++) begin
      // last < N, so one conditional subtract is enough to wrap.
      idxI = int'(last) + off;
      if (idxI >= N) idxI = idxI - N;
      idx = PTR_W'(idxI);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        winner   = idx;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter. It shares the single-port data memory between the
// cores and the UART memory-communication interface.
// Arbitration is combinational: a valid lock owner that still requests wins.
// Otherwise round-robin picks the winner. The access goes to the memory port
// in the same cycle.
// Read data is tagged with the issuing requester. The tag is delayed by the
// memory read latency.
//   clk, rstN   : clock, asynchronous active-low reset
//   req/lock/we : per-requester request, burst lock, write select
//   addr/wdata  : flattened per-requester address / write data
//   gnt         : one-hot grant (access issued this cycle)
//   rvalid      : one-hot owner of rdata this cycle
//   rdata       : mem_q passthrough
//   mem_*       : memory port (address, write enable, write data, read data)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int N_REQ          = REQ_COUNT,
  parameter int ADDR_WIDTH     = DATA_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DATA_MEM_WIDTH,
  parameter int MEM_RD_LATENCY = 1,
  parameter int MAX_LOCK       = 16
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            lock,
  input  logic [N_REQ-1:0]            we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic                        mem_wrEn,
  output logic [DATA_WIDTH-1:0]       mem_dataIn,
  input  logic [DATA_WIDTH-1:0]       mem_q
);

  localparam int               PTR_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int               CNT_W        = $clog2(MAX_LOCK) + 1;
  localparam logic [PTR_W-1:0] LAST_RESET   = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT    = CNT_W'(MAX_LOCK - 1);
  // With a single requester the grant is simply req. Locking cannot change it.
  localparam bit               LOCK_ALLOWED = (N_REQ > 1);

  logic [PTR_W-1:0]      last;
  logic [PTR_W-1:0]      owner;
  logic                  ownerValid;
  logic [CNT_W-1:0]      lockCnt;
  logic [CNT_W-1:0]      lockBase;
  logic [N_REQ-1:0]      rrGnt;
  logic [PTR_W-1:0]      rrWinner;
  logic [PTR_W-1:0]      winner;
  logic                  ownerWins;
  logic                  anyGnt;
  logic [ADDR_WIDTH-1:0] addrArr  [N_REQ];
  logic [DATA_WIDTH-1:0] wdataArr [N_REQ];
  logic [ADDR_WIDTH-1:0] addrHold;
  logic [DATA_WIDTH-1:0] dataHold;
  logic                  tagValid [MEM_RD_LATENCY];
  logic [PTR_W-1:0]      tagId    [MEM_RD_LATENCY];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addrArr[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdataArr[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rrPick (
    .req    (req),
    .last   (last),
    .gnt    (rrGnt),
    .winner (rrWinner)
  );

  // An owner that drops req loses the lock right away. This cycle falls back
  // to plain round-robin.
  assign ownerWins = ownerValid && req[owner];
  assign anyGnt    = |req;
  assign winner    = ownerWins ? owner : rrWinner;

  always_comb begin
    gnt = rrGnt;
    if (ownerWins) begin
      gnt        = '0;
      gnt[owner] = 1'b1;
    end
  end

  // When idle, the address and data lines keep their last values so the
  // memory inputs do not toggle.
  assign mem_addr   = anyGnt ? addrArr[winner]  : addrHold;
  assign mem_dataIn = anyGnt ? wdataArr[winner] : dataHold;
  assign mem_wrEn   = anyGnt & we[winner];

  // A burst keeps counting only while the owner keeps winning. A newly
  // locked grant starts from zero.
  assign lockBase = ownerWins ? lockCnt : '0;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      last       <= LAST_RESET;
      owner      <= '0;
      ownerValid <= 1'b0;
      lockCnt    <= '0;
      addrHold   <= '0;
      dataHold   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then samples the pre-edge values of the others.
      addrHold <= mem_addr;
      dataHold <= mem_dataIn;
      if (anyGnt) begin
        last <= winner;
        // The grant that reaches MAX_LOCK clears the owner, so the next
        // arbitration is ordinary round-robin starting after this winner.
        if (LOCK_ALLOWED && lock[winner] && (lockBase < CNT_LIMIT)) begin
          owner      <= winner;
          ownerValid <= 1'b1;
          lockCnt    <= lockBase + CNT_W'(1);
        end else begin
          ownerValid <= 1'b0;
          lockCnt    <= '0;
        end
      end else begin
        ownerValid <= 1'b0;
        lockCnt    <= '0;
      end
    end
  end

  // The read tag travels alongside the memory access. Its final stage lines
  // up with mem_q.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      // NOTE: this tag pipeline is explicitly reset, unlike a data RAM.
      // Stale valid bits would fire spurious rvalid pulses after reset.
      for (int k = 0; k < MEM_RD_LATENCY; k++) begin
        tagValid[k] <= 1'b0;
        tagId[k]    <= '0;
      end
    end else begin
      tagValid[0] <= anyGnt & ~we[winner];
      tagId[0]    <= winner;
      for (int k = 1; k < MEM_RD_LATENCY; k++) begin
        tagValid[k] <= tagValid[k-1];
        tagId[k]    <= tagId[k-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (tagValid[MEM_RD_LATENCY-1]) rvalid[tagId[MEM_RD_LATENCY-1]] = 1'b1;
  end

  assign rdata = mem_q;

endmodule
